// File: rtl/i2c_slave_responder_if.sv
// i2c_slave_responder_if: I2C line, write-data and read-data signals of the responder
interface i2c_slave_responder_if;
    logic       scl_i;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic [7:0] rd_data;
    logic       rd_req;
    logic       busy;
    logic       stop_det;
    modport slave (
        input  scl_i, sda_i, rd_data,
        output sda_oe, wr_data, wr_valid, rd_req, busy, stop_det
    );
    modport master (
        output scl_i, sda_i, rd_data,
        input  sda_oe, wr_data, wr_valid, rd_req, busy, stop_det
    );
endinterface

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: I2C target that ACKs its address, captures written bytes and serves read bytes
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h22,
    parameter int         SYNC_STAGES = 2
) (
    input logic clk,
    input logic s_rst,
    i2c_slave_responder_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
    logic scl_s, sda_s, scl_d, sda_d, rise_q, fall_q, start, stop, load_rd;
    logic [2:0] cnt, cnt_n;
    logic [7:0] shift, shift_n, wr_data, wr_data_n, byte_in;
    logic rw, rw_n, oe, oe_n, wr_valid, wr_valid_n, rd_req, rd_req_n, busy, busy_n, stop_det, stop_det_n;
    assign scl_s   = scl_sr[SYNC_STAGES-1];
    assign sda_s   = sda_sr[SYNC_STAGES-1];
    assign start   = scl_s & scl_d & sda_d & ~sda_s;
    assign stop    = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_in = {shift[6:0], sda_d};
    // Edge pulses are registered, so sda_d is the line value at the rising edge
    always_ff @(posedge clk) begin
        if (s_rst) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], bus.scl_i};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], bus.sda_i};
            scl_d  <= scl_s;
            sda_d  <= sda_s;
            rise_q <= scl_s & ~scl_d;
            fall_q <= ~scl_s & scl_d;
        end
    end
    always_ff @(posedge clk) begin
        if (s_rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            shift    <= 8'h00;
            rw       <= 1'b0;
            oe       <= 1'b0;
            wr_data  <= 8'h00;
            wr_valid <= 1'b0;
            rd_req   <= 1'b0;
            busy     <= 1'b0;
            stop_det <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            shift    <= shift_n;
            rw       <= rw_n;
            oe       <= oe_n;
            wr_data  <= wr_data_n;
            wr_valid <= wr_valid_n;
            rd_req   <= rd_req_n;
            busy     <= busy_n;
            stop_det <= stop_det_n;
        end
    end
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        shift_n    = shift;
        rw_n       = rw;
        oe_n       = oe;
        wr_data_n  = wr_data;
        wr_valid_n = 1'b0;
        rd_req_n   = 1'b0;
        busy_n     = busy;
        stop_det_n = 1'b0;
        load_rd    = 1'b0;
        if (start) begin
            state_n = ADDR;
            cnt_n   = 3'd0;
            oe_n    = 1'b0;
        end else if (stop) begin
            state_n    = IDLE;
            oe_n       = 1'b0;
            busy_n     = 1'b0;
            stop_det_n = 1'b1;
        end else begin
            case (state)
                ADDR: if (rise_q) begin
                    shift_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        rw_n    = sda_d;
                        busy_n  = byte_in[7:1] == SLAVE_ADDR;
                        state_n = byte_in[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
                    end
                end
                // oe itself marks whether the ACK low phase has begun
                ADDR_ACK, WR_ACK: if (fall_q) begin
                    if (!oe) oe_n = 1'b1;
                    else if (state == WR_ACK || !rw) begin
                        oe_n    = 1'b0;
                        state_n = WR_BYTE;
                    end else load_rd = 1'b1;
                end
                WR_BYTE: if (rise_q) begin
                    shift_n = byte_in;
                    cnt_n   = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        wr_data_n  = byte_in;
                        wr_valid_n = 1'b1;
                        state_n    = WR_ACK;
                    end
                end
                RD_BYTE: if (rise_q) cnt_n = cnt + 3'd1;
                else if (fall_q) begin
                    state_n = cnt == 3'd0 ? RD_ACK : RD_BYTE;
                    oe_n    = cnt == 3'd0 ? 1'b0 : ~shift[6];
                    shift_n = {shift[6:0], 1'b0};
                end
                RD_ACK: if (rise_q && sda_d) begin
                    state_n = IGNORE;
                    busy_n  = 1'b0;
                    oe_n    = 1'b0;
                end else if (fall_q) load_rd = 1'b1;
                default: ;
            endcase
        end
        if (load_rd) begin
            rd_req_n = 1'b1;
            shift_n  = bus.rd_data;
            oe_n     = ~bus.rd_data[7];
            cnt_n    = 3'd0;
            state_n  = RD_BYTE;
        end
    end
    assign bus.sda_oe   = oe;
    assign bus.wr_data  = wr_data;
    assign bus.wr_valid = wr_valid;
    assign bus.rd_req   = rd_req;
    assign bus.busy     = busy;
    assign bus.stop_det = stop_det;
endmodule

// File: doc/i2c_slave_responder.md
I2C_SLAVE_RESPONDER -- requirements
Module: i2c_slave_responder

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h22: the 7-bit address the block answers to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth for scl_i and sda_i; legal range 2-3.
REQ-003 SHALL have one clock and a synchronous, active-high reset; all state changes occur on the rising edge of clk.
REQ-004 clk  input  1  system clock.
REQ-005 s_rst  input  1  synchronous active-high reset.
REQ-006 scl_i  input  1  I2C clock line, asynchronous to clk.
REQ-007 sda_i  input  1  I2C data line, asynchronous to clk.
REQ-008 sda_oe  output  1  1 = pull SDA low; 0 = release SDA.
REQ-009 wr_data  output  8  last byte written by the master.
REQ-010 wr_valid  output  1  one-clk pulse when wr_data is updated.
REQ-011 rd_data  input  8  byte to send on the next read-byte slot.
REQ-012 rd_req  output  1  one-clk pulse when rd_data is sampled.
REQ-013 busy  output  1  high from an address match until STOP or NACK exit.
REQ-014 stop_det  output  1  one-clk pulse on every STOP condition.

Function
REQ-015 SHALL pass scl_i and sda_i through SYNC_STAGES flops; all detection uses the synchronized values (scl_s, sda_s) and their one-cycle-delayed copies.
REQ-016 START / repeated START: sda_s falls while scl_s is high and was high in the previous cycle.
REQ-017 STOP: sda_s rises while scl_s is high and was high in the previous cycle.
REQ-018 Sample edge = scl_s rising; drive edge = scl_s falling.
REQ-019 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-020 START from any state → ADDR, bit counter = 0, sda_oe = 0; this also covers a repeated START in mid-byte.
REQ-021 STOP from any state → IDLE, sda_oe = 0, busy = 0, stop_det pulses.
REQ-022 ADDR shifts 8 bits MSB first, one per sample edge: 7 address bits, then R/W (1 = read).
REQ-023 After the 8th bit:
- address == SLAVE_ADDR → ADDR_ACK; busy = 1.
- otherwise → IGNORE with sda_oe held 0.
REQ-024 IGNORE does nothing until START or STOP.
REQ-025 ADDR_ACK: sda_oe = 1 from the next drive edge through the following drive edge.
REQ-026 On the drive edge that ends ADDR_ACK:
- write → WR_BYTE.
- read → RD_BYTE; rd_req pulses, rd_data is latched into the shift register, and the MSB is driven on that same drive edge.
REQ-027 WR_BYTE shifts 8 bits, then:
- wr_data is updated and wr_valid pulses in the cycle after the 8th sample edge.
- → WR_ACK, which drives ACK exactly as ADDR_ACK does, then returns to WR_BYTE.
REQ-028 RD_BYTE drive rule: sda_oe = ~current_bit, changing only on drive edges; after 8 bits sda_oe = 0 and → RD_ACK.
REQ-029 RD_ACK samples the master's ACK bit on the sample edge:
- 0 (ACK) → on the next drive edge, rd_req pulses, the next byte is latched, RD_BYTE.
- 1 (NACK) → IGNORE, busy = 0, sda_oe = 0.
REQ-030 sda_oe changes only in the cycle after a detected drive edge, except that START, STOP and reset clear it immediately.
REQ-031 START/STOP detection takes priority over an edge detected in the same cycle; sda changes while scl is high are never treated as data.
REQ-032 Latency from a raw scl_i falling edge to an sda_oe change is SYNC_STAGES+2 clk.
REQ-033 The bit counter wraps 7→0 per byte; transfers of any number of bytes are legal.

Reset
REQ-034 While s_rst is high on a rising clk edge, all of the following SHALL hold: state = IDLE, sda_oe = 0, wr_data = 8'h00, wr_valid = 0, rd_req = 0, busy = 0, stop_det = 0, synchronizer flops = 1.
REQ-035 Reset mid-transfer SHALL release SDA in the next cycle; the block SHALL ignore bus activity until a new START.

Verification
REQ-036 Write: START, 0x44, 0xA5, 0x3C, STOP → ACK on the address and both data bytes; wr_valid pulses twice with wr_data = 0xA5, then 0x3C; stop_det pulses once; busy ends 0.
REQ-037 Read: START, 0x45, rd_data = 0x96 then 0x0F, master ACK then NACK, STOP → SDA carries 1001_0110 then 0000_1111; rd_req pulses twice; the block enters IGNORE after the NACK.
REQ-038 Address miss: START, 0x50 → sda_oe stays 0 throughout; busy stays 0; no wr_valid or rd_req.
REQ-039 Repeated START: START, 0x44, 0x11, Sr, 0x45, read 1 byte, NACK, STOP → wr_data = 0x11; one rd_req; ACK on both addresses.
REQ-040 Abort: STOP injected after 3 bits of a write byte → IDLE; no wr_valid; sda_oe = 0.
REQ-041 Reset during the RD_BYTE drive-low phase → sda_oe = 0 the next cycle; a following START + 0x44 is ACKed normally.
